// File: rtl/psum_accum_pkg.sv
// psum_accum_pkg: shared widths for the partial-sum accumulator.
// The zebranet defines (BITWIDTH, OUT_CHANNEL, BW_FL) normally come from the
// accelerator-wide header; defaults are provided here when it is absent.
// The derived partial-sum / bias width expressions live beside them so that
// this block and the post-processing stage compute identical widths.

`ifndef BITWIDTH
`define BITWIDTH 8
`endif
`ifndef OUT_CHANNEL
`define OUT_CHANNEL 4
`endif
`ifndef BW_FL
`define BW_FL 5
`endif
`ifndef BW_PSUM_OF
`define BW_PSUM_OF(gc) (2*`BITWIDTH+4+$clog2(gc))
`endif
`ifndef BW_BIAS_OF
`define BW_BIAS_OF(gc) (2*`BITWIDTH+4+$clog2(gc)+1)
`endif

package psum_accum_pkg;

  localparam int BITWIDTH          = `BITWIDTH;
  localparam int OUT_CHANNEL       = `OUT_CHANNEL;
  localparam int BW_FL             = `BW_FL;
  localparam int DEF_GROUP_CHANNEL = 16;
  localparam int DEF_MAX_GROUPS    = 16;
  localparam int PSUM_W            = `BW_PSUM_OF(DEF_GROUP_CHANNEL);
  localparam int BIAS_W            = `BW_BIAS_OF(DEF_GROUP_CHANNEL);
  localparam int CNT_W             = $clog2(DEF_MAX_GROUPS + 1);

endpackage

// File: rtl/psum_accum_if.sv
// psum_accum_if: bus between the PE-array side driver and psum_accum.
//   master : drives clear, num_groups, in_valid, psum_in, bias, bias_shift;
//            observes out_valid, post_in, busy.
//   slave  : the accumulator's view (directions reversed).
// Vectors are packed with channel 0 in the MSBs.

interface psum_accum_if;
  import psum_accum_pkg::*;

  logic                            clear;
  logic [CNT_W-1:0]                num_groups;
  logic                            in_valid;
  logic [OUT_CHANNEL*PSUM_W-1:0]   psum_in;
  logic [OUT_CHANNEL*BITWIDTH-1:0] bias;
  logic [BW_FL-1:0]                bias_shift;
  logic                            out_valid;
  logic [OUT_CHANNEL*BIAS_W-1:0]   post_in;
  logic                            busy;

  modport master (
    output clear, num_groups, in_valid, psum_in, bias, bias_shift,
    input  out_valid, post_in, busy
  );

  modport slave (
    input  clear, num_groups, in_valid, psum_in, bias, bias_shift,
    output out_valid, post_in, busy
  );

endinterface

// File: rtl/psum_accum_1ch.sv
// psum_acc_1ch: combinational datapath for one output channel.
//   first      : 1 on the first beat of a pixel (start from aligned bias)
//   psum       : signed partial sum of this beat
//   bias       : signed raw bias
//   bias_shift : left shift aligning bias to the accumulator fraction
//   acc        : running accumulation from previous beats
//   sum        : saturated result of this beat

module psum_acc_1ch #(
  parameter int BW_PSUM = 24,
  parameter int BW_BIAS = 25,
  parameter int BW_B    = 8,
  parameter int BW_SH   = 5
) (
  input  logic                      first,
  input  logic signed [BW_PSUM-1:0] psum,
  input  logic signed [BW_B-1:0]    bias,
  input  logic [BW_SH-1:0]          bias_shift,
  input  logic signed [BW_BIAS-1:0] acc,
  output logic signed [BW_BIAS-1:0] sum
);

  // Wide intermediate gives headroom for the bias shift before clamping.
  localparam int WW = BW_BIAS + 16;
  localparam logic signed [WW-1:0] SAT_MAX = {{17{1'b0}}, {(BW_BIAS-1){1'b1}}};
  localparam logic signed [WW-1:0] SAT_MIN = {{17{1'b1}}, {(BW_BIAS-1){1'b0}}};

  function automatic logic signed [BW_BIAS-1:0] clamp(input logic signed [WW-1:0] x);
    if (x > SAT_MAX)
      return SAT_MAX[BW_BIAS-1:0];
    else if (x < SAT_MIN)
      return SAT_MIN[BW_BIAS-1:0];
    else
      return x[BW_BIAS-1:0];
  endfunction

  logic signed [WW-1:0]      bias_sh;
  logic signed [BW_BIAS-1:0] bias_al;
  logic signed [BW_BIAS-1:0] addend;
  logic signed [WW-1:0]      sum_w;

  always_comb begin
    bias_sh = {{(WW-BW_B){bias[BW_B-1]}}, bias} << bias_shift;
    bias_al = clamp(bias_sh);
    addend  = first ? bias_al : acc;
    sum_w   = {{(WW-BW_BIAS){addend[BW_BIAS-1]}}, addend}
            + {{(WW-BW_PSUM){psum[BW_PSUM-1]}}, psum};
    sum     = clamp(sum_w);
  end

endmodule

// File: rtl/psum_accum.sv
// psum_accum: accumulates per-group partial sums from the PE array over a
// runtime number of groups, adds the aligned bias on the first beat,
// saturates, and presents the result to the post-processing stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : clear, num_groups, in_valid, psum_in, bias, bias_shift in;
//                out_valid (1-cycle pulse), post_in (held), busy out.

module psum_accum
  import psum_accum_pkg::*;
#(
  parameter int GROUP_CHANNEL = DEF_GROUP_CHANNEL,
  parameter int BW_PSUM       = 2*BITWIDTH + 4 + $clog2(GROUP_CHANNEL),
  parameter int BW_BIAS       = 2*BITWIDTH + 4 + $clog2(GROUP_CHANNEL) + 1,
  parameter int MAX_GROUPS    = DEF_MAX_GROUPS
) (
  input  logic        clk,
  input  logic        rst_n,
  psum_accum_if.slave bus
);

  localparam int CW = $clog2(MAX_GROUPS + 1);

  logic [CW-1:0]                 cnt_reg;
  logic [CW-1:0]                 g_reg;
  logic [CW-1:0]                 g_next;
  logic                          first;
  logic                          last;
  logic                          out_valid_reg;
  logic [OUT_CHANNEL*BW_BIAS-1:0] post_reg;
  logic [OUT_CHANNEL*BW_BIAS-1:0] sum_flat;
  logic signed [BW_BIAS-1:0]     acc_reg [OUT_CHANNEL];

  assign first  = (cnt_reg == '0);
  // A programmed count of 0 means a single group per pixel.
  assign g_next = (bus.num_groups == '0) ? CW'(1) : bus.num_groups;
  // On the first beat the freshly latched count decides; later the held one.
  assign last   = first ? (g_next == CW'(1)) : ((cnt_reg + CW'(1)) == g_reg);

  for (genvar gi = 0; gi < OUT_CHANNEL; gi++) begin : g_ch
    localparam int SLOT = OUT_CHANNEL - 1 - gi;
    psum_acc_1ch #(
      .BW_PSUM (BW_PSUM),
      .BW_BIAS (BW_BIAS),
      .BW_B    (BITWIDTH),
      .BW_SH   (BW_FL)
    ) u_ch (
      .first      (first),
      .psum       (bus.psum_in[SLOT*BW_PSUM +: BW_PSUM]),
      .bias       (bus.bias[SLOT*BITWIDTH +: BITWIDTH]),
      .bias_shift (bus.bias_shift),
      .acc        (acc_reg[gi]),
      .sum        (sum_flat[SLOT*BW_BIAS +: BW_BIAS])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      g_reg         <= CW'(1);
      out_valid_reg <= 1'b0;
      post_reg      <= '0;
      for (int i = 0; i < OUT_CHANNEL; i++) acc_reg[i] <= '0;
    end else if (bus.clear) begin
      // Abort: the beat in this cycle is dropped, post_in keeps its value.
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else if (bus.in_valid) begin
      if (first) g_reg <= g_next;
      if (last) begin
        post_reg      <= sum_flat;
        out_valid_reg <= 1'b1;
        cnt_reg       <= '0;
      end else begin
        for (int i = 0; i < OUT_CHANNEL; i++)
          acc_reg[i] <= sum_flat[(OUT_CHANNEL-1-i)*BW_BIAS +: BW_BIAS];
        cnt_reg       <= cnt_reg + CW'(1);
        out_valid_reg <= 1'b0;
      end
    end else begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.post_in   = post_reg;
  assign bus.busy      = (cnt_reg != '0);

endmodule

// File: tb/tb_psum_accum.sv
// tb_psum_accum: directed vector table, hand-written reset sequence and a
// randomized run checked against an arithmetic reference model.

`timescale 1ns/1ps

module tb_psum_accum;
  import psum_accum_pkg::*;

  localparam int NC  = OUT_CHANNEL;
  localparam int PW  = PSUM_W;
  localparam int BWB = BIAS_W;
  localparam int BW  = BITWIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  psum_accum_if bus ();

  psum_accum dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic             clr;
    logic             vld;
    logic [CNT_W-1:0] ng;
    logic [NC*PW-1:0] ps;
    logic [NC*BW-1:0] bs;
    logic [BW_FL-1:0] sh;
    logic             e_ov;
    logic             e_busy;
    logic [NC*BWB-1:0] e_post;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [NC*PW-1:0] pk_ps(int a, int b, int c, int d);
    int v[4];
    logic [NC*PW-1:0] r;
    v = '{a, b, c, d};
    r = '0;
    for (int i = 0; i < 4; i++) r[(NC-1-i)*PW +: PW] = v[i][PW-1:0];
    return r;
  endfunction

  function automatic logic [NC*BW-1:0] pk_b(int a, int b, int c, int d);
    int v[4];
    logic [NC*BW-1:0] r;
    v = '{a, b, c, d};
    r = '0;
    for (int i = 0; i < 4; i++) r[(NC-1-i)*BW +: BW] = v[i][BW-1:0];
    return r;
  endfunction

  function automatic logic [NC*BWB-1:0] pk_p(longint a, longint b, longint c, longint d);
    longint v[4];
    logic [NC*BWB-1:0] r;
    v = '{a, b, c, d};
    r = '0;
    for (int i = 0; i < 4; i++) r[(NC-1-i)*BWB +: BWB] = v[i][BWB-1:0];
    return r;
  endfunction

  function automatic vec_t mk(logic clr, logic vld, int ng, logic [NC*PW-1:0] ps,
                              logic [NC*BW-1:0] bs, int sh, logic e_ov, logic e_busy,
                              logic [NC*BWB-1:0] e_post);
    vec_t v;
    v.clr = clr; v.vld = vld; v.ng = CNT_W'(ng); v.ps = ps; v.bs = bs;
    v.sh = BW_FL'(sh); v.e_ov = e_ov; v.e_busy = e_busy; v.e_post = e_post;
    return v;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic clr, logic vld, logic [CNT_W-1:0] ng, logic [NC*PW-1:0] ps,
                       logic [NC*BW-1:0] bs, logic [BW_FL-1:0] sh);
    bus.clear      = clr;
    bus.in_valid   = vld;
    bus.num_groups = ng;
    bus.psum_in    = ps;
    bus.bias       = bs;
    bus.bias_shift = sh;
  endtask

  // Reference model: plain integer arithmetic on the current pixel.
  longint m_acc[4];
  longint m_post[4];
  int     m_cnt;
  int     m_g;
  bit     m_ov;
  int     ps_i[4];
  int     bs_i[4];

  function automatic longint clampl(longint x);
    longint hi, lo;
    hi = (longint'(1) <<< (BWB-1)) - 1;
    lo = -(longint'(1) <<< (BWB-1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_g = 1; m_ov = 0;
    for (int i = 0; i < 4; i++) begin m_acc[i] = 0; m_post[i] = 0; end
  endtask

  task automatic model_step(bit clr, bit vld, int ng, int sh);
    if (clr) begin
      m_cnt = 0; m_ov = 0;
    end else if (vld) begin
      if (m_cnt == 0) begin
        m_g = (ng == 0) ? 1 : ng;
        for (int i = 0; i < 4; i++)
          m_acc[i] = clampl(clampl(longint'(bs_i[i]) * (longint'(1) <<< sh)) + longint'(ps_i[i]));
      end else begin
        for (int i = 0; i < 4; i++) m_acc[i] = clampl(m_acc[i] + longint'(ps_i[i]));
      end
      m_cnt++;
      if (m_cnt == m_g) begin
        for (int i = 0; i < 4; i++) m_post[i] = m_acc[i];
        m_ov = 1; m_cnt = 0;
      end else begin
        m_ov = 0;
      end
    end else begin
      m_ov = 0;
    end
  endtask

  function automatic int rand_psum();
    logic signed [PW-1:0] t;
    case ($urandom_range(0, 3))
      0: begin t = PW'($urandom); return int'(t); end
      1: return ($urandom_range(0, 1) == 1) ? (1 <<< (PW-1)) - 1 : -(1 <<< (PW-1));
      default: return int'($urandom_range(0, 2000)) - 1000;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NC*BWB-1:0] p300, sat_p, sat_n, p4, p21, p1, pm;
    logic [NC*PW-1:0]  x100, x55, x1, x7, x0;

    drive(0, 0, 0, '0, '0, 0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 128'(bus.out_valid), 128'(0));
    chk("reset_busy", 128'(bus.busy), 128'(0));
    chk("reset_post_in", 128'(bus.post_in), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    x100 = pk_ps(100, 100, 100, 100);
    x55  = pk_ps(55, 55, 55, 55);
    x1   = pk_ps(1, 1, 1, 1);
    x7   = pk_ps(7, 7, 7, 7);
    x0   = pk_ps(0, 0, 0, 0);
    pm    = pk_p(14, 6, -5, 8);
    p300  = pk_p(300, 300, 300, 300);
    sat_p = pk_p(16777215, 0, 0, 0);
    sat_n = pk_p(-16777216, 0, 0, 0);
    p4    = pk_p(4, 4, 4, 4);
    p21   = pk_p(21, 21, 21, 21);
    p1    = pk_p(1, 1, 1, 1);

    tbl.push_back(mk(0, 1, 1, pk_ps(10, 10, -5, 0), pk_b(1, -1, 0, 2), 2, 1, 0, pm));
    tbl.push_back(mk(0, 0, 1, x55, pk_b(0, 0, 0, 0), 0, 0, 0, pm));
    tbl.push_back(mk(0, 1, 3, x100, pk_b(0, 0, 0, 0), 0, 0, 1, pm));
    tbl.push_back(mk(0, 1, 7, x100, pk_b(9, 9, 9, 9), 3, 0, 1, pm));
    tbl.push_back(mk(0, 1, 7, x100, pk_b(9, 9, 9, 9), 3, 1, 0, p300));
    tbl.push_back(mk(0, 1, 2, pk_ps(8388607, 0, 0, 0), pk_b(127, 0, 0, 0), 10, 0, 1, p300));
    tbl.push_back(mk(0, 1, 2, pk_ps(8388607, 0, 0, 0), pk_b(-128, 0, 0, 0), 10, 1, 0, sat_p));
    tbl.push_back(mk(0, 1, 2, pk_ps(-8388608, 0, 0, 0), pk_b(-128, 0, 0, 0), 10, 0, 1, sat_p));
    tbl.push_back(mk(0, 1, 2, pk_ps(-8388608, 0, 0, 0), pk_b(-128, 0, 0, 0), 10, 1, 0, sat_n));
    tbl.push_back(mk(0, 1, 4, x1, pk_b(0, 0, 0, 0), 0, 0, 1, sat_n));
    tbl.push_back(mk(0, 0, 4, x55, pk_b(0, 0, 0, 0), 0, 0, 1, sat_n));
    tbl.push_back(mk(0, 0, 4, x55, pk_b(0, 0, 0, 0), 0, 0, 1, sat_n));
    tbl.push_back(mk(0, 1, 4, x1, pk_b(0, 0, 0, 0), 0, 0, 1, sat_n));
    tbl.push_back(mk(0, 1, 4, x1, pk_b(0, 0, 0, 0), 0, 0, 1, sat_n));
    tbl.push_back(mk(0, 1, 4, x1, pk_b(0, 0, 0, 0), 0, 1, 0, p4));
    tbl.push_back(mk(0, 1, 3, x7, pk_b(0, 0, 0, 0), 0, 0, 1, p4));
    tbl.push_back(mk(0, 1, 3, x7, pk_b(0, 0, 0, 0), 0, 0, 1, p4));
    tbl.push_back(mk(1, 1, 3, x7, pk_b(0, 0, 0, 0), 0, 0, 0, p4));
    tbl.push_back(mk(0, 1, 3, x7, pk_b(0, 0, 0, 0), 0, 0, 1, p4));
    tbl.push_back(mk(0, 1, 3, x7, pk_b(0, 0, 0, 0), 0, 0, 1, p4));
    tbl.push_back(mk(0, 1, 3, x7, pk_b(0, 0, 0, 0), 0, 1, 0, p21));
    tbl.push_back(mk(0, 1, 0, pk_ps(5, -3, 9, 0), pk_b(1, 1, 1, 1), 0, 1, 0, pk_p(6, -2, 10, 1)));
    tbl.push_back(mk(0, 1, 0, x1, pk_b(0, 0, 0, 0), 0, 1, 0, p1));
    tbl.push_back(mk(0, 0, 0, x0, pk_b(0, 0, 0, 0), 0, 0, 0, p1));

    foreach (tbl[k]) begin
      drive(tbl[k].clr, tbl[k].vld, tbl[k].ng, tbl[k].ps, tbl[k].bs, tbl[k].sh);
      @(posedge clk); #1;
      $display("[TB] vec %0d clr=%0b vld=%0b ng=%0d -> out_valid=%0b busy=%0b post_in=%h",
               k, tbl[k].clr, tbl[k].vld, tbl[k].ng, bus.out_valid, bus.busy, bus.post_in);
      chk($sformatf("vec%0d_out_valid", k), 128'(bus.out_valid), 128'(tbl[k].e_ov));
      chk($sformatf("vec%0d_busy", k), 128'(bus.busy), 128'(tbl[k].e_busy));
      chk($sformatf("vec%0d_post_in", k), 128'(bus.post_in), 128'(tbl[k].e_post));
    end

    // Asynchronous reset in the middle of a 3-group pixel.
    drive(0, 1, 3, pk_ps(50, 50, 50, 50), pk_b(0, 0, 0, 0), 0);
    @(posedge clk); #1;
    chk("rst_pre_busy", 128'(bus.busy), 128'(1));
    rst_n = 1'b0;
    #1;
    $display("[TB] async reset mid-pixel -> out_valid=%0b busy=%0b post_in=%h",
             bus.out_valid, bus.busy, bus.post_in);
    chk("rst_async_busy", 128'(bus.busy), 128'(0));
    chk("rst_async_post_in", 128'(bus.post_in), 128'(0));
    chk("rst_async_out_valid", 128'(bus.out_valid), 128'(0));
    drive(0, 0, 3, x0, pk_b(0, 0, 0, 0), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int b = 0; b < 3; b++) begin
      drive(0, 1, 3, pk_ps(9, 9, 9, 9), pk_b(0, 0, 0, 0), 0);
      @(posedge clk); #1;
      $display("[TB] post-reset beat %0d -> out_valid=%0b busy=%0b post_in=%h",
               b, bus.out_valid, bus.busy, bus.post_in);
      chk($sformatf("rst_beat%0d_out_valid", b), 128'(bus.out_valid), 128'(b == 2));
      chk($sformatf("rst_beat%0d_busy", b), 128'(bus.busy), 128'(b != 2));
    end
    chk("rst_fresh_sum", 128'(bus.post_in), 128'(pk_p(27, 27, 27, 27)));

    // Randomized run against the reference model, from a clean reset.
    drive(0, 0, 0, x0, pk_b(0, 0, 0, 0), 0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    for (int n = 0; n < 600; n++) begin
      bit clr, vld;
      int ng, sh;
      logic [NC*PW-1:0] psv;
      logic [NC*BW-1:0] bsv;
      logic [NC*BWB-1:0] ep;
      clr = ($urandom_range(0, 19) == 0);
      vld = ($urandom_range(0, 3) != 0);
      ng  = $urandom_range(0, DEF_MAX_GROUPS);
      sh  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (1 << BW_FL) - 1) : $urandom_range(0, 4);
      for (int i = 0; i < 4; i++) begin
        ps_i[i] = rand_psum();
        bs_i[i] = int'($urandom_range(0, 255)) - 128;
      end
      psv = pk_ps(ps_i[0], ps_i[1], ps_i[2], ps_i[3]);
      bsv = pk_b(bs_i[0], bs_i[1], bs_i[2], bs_i[3]);
      drive(clr, vld, CNT_W'(ng), psv, bsv, BW_FL'(sh));
      model_step(clr, vld, ng, sh);
      @(posedge clk); #1;
      ep = pk_p(m_post[0], m_post[1], m_post[2], m_post[3]);
      if (m_ov || bus.out_valid)
        $display("[TB] rnd %0d output post_in=%h model=%h", n, bus.post_in, ep);
      chk($sformatf("rnd%0d_out_valid", n), 128'(bus.out_valid), 128'(m_ov));
      chk($sformatf("rnd%0d_busy", n), 128'(bus.busy), 128'(m_cnt != 0));
      chk($sformatf("rnd%0d_post_in", n), 128'(bus.post_in), 128'(ep));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
